// File: rtl/pcpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the 5-stage pipelined CPU.
// Drives the CPU enable/start pair and keeps cycle/status counters for the debug display.
module pcpu_run_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter logic [4:0]  HALT_OP = 5'b00001
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              stop_req,
  input  logic [7:0]        step_n,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [4:0]        wb_op,
  output logic              enable,
  output logic              start,
  output logic              busy,
  output logic [1:0]        state_o,
  output logic [1:0]        stop_cause,
  output logic [CNT_W-1:0]  cyc_cnt
);

  localparam int unsigned STEP_W  = 8;
  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ARM    = 2'b01,
    S_EXEC   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  typedef enum logic {
    M_RUN  = 1'b0,
    M_STEP = 1'b1
  } mode_t;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_STEP = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_BP   = 2'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_STOP = 2'd3;

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [STEP_W-1:0]   remain_q, remain_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic bp_hit;
  logic last_step;
  logic wb_halt;

  assign bp_hit    = bp_en && (i_addr == bp_addr);
  assign last_step = (mode_q == M_STEP) && (remain_q == STEP_W'(1));
  assign wb_halt   = (wb_op == HALT_OP);

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= M_RUN;
      remain_q <= '0;
      cause_q  <= CAUSE_NONE;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      remain_q <= remain_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state, datapath updates and CPU handshake
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    remain_d = remain_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    enable   = 1'b0;
    start    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run_req) begin
          mode_d  = M_RUN;
          cause_d = CAUSE_NONE;
          state_d = S_ARM;
        end else if (step_req) begin
          mode_d   = M_STEP;
          remain_d = (step_n == '0) ? STEP_W'(1) : step_n;
          cause_d  = CAUSE_NONE;
          state_d  = S_ARM;
        end
      end

      S_ARM: begin
        enable  = 1'b1;
        start   = 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        // Dropping enable still lets the CPU advance on this edge, then it leaves exec
        enable = !(stop_req || bp_hit || last_step);
        cnt_d  = cnt_q + CNT_W'(1);
        if (mode_q == M_STEP) begin
          remain_d = remain_q - STEP_W'(1);
        end
        if (wb_halt) begin
          state_d = S_HALTED;
        end else if (stop_req) begin
          state_d = S_IDLE;
          cause_d = CAUSE_STOP;
        end else if (bp_hit) begin
          state_d = S_IDLE;
          cause_d = CAUSE_BP;
        end else if (last_step) begin
          state_d = S_IDLE;
          cause_d = CAUSE_STEP;
        end
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q == S_ARM) || (state_q == S_EXEC);
  assign state_o    = state_q;
  assign stop_cause = cause_q;
  assign cyc_cnt    = cnt_q;

endmodule

// File: tb/tb_pcpu_run_ctrl.sv
// Bench for pcpu_run_ctrl: a tiny 5-stage CPU stand-in plus an abstract controller model,
// directed scenario table, hand sequences, random traffic and a counter-wrap run.
module tb_pcpu_run_ctrl;

  localparam logic [4:0] HALT = 5'b00001;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run_req = 1'b0, step_req = 1'b0, stop_req = 1'b0;
  logic [7:0] step_n = 8'd0;
  logic       bp_en = 1'b0;
  logic [7:0] bp_addr = 8'd0;
  logic [7:0] i_addr = 8'd0;
  logic [4:0] wb_op = 5'd0;
  logic       enable, start, busy;
  logic [1:0] state_o, stop_cause;
  logic [15:0] cyc_cnt;

  pcpu_run_ctrl #(.CNT_W(16), .ADDR_W(8), .HALT_OP(HALT)) dut (
    .clock(clock), .reset(reset), .run_req(run_req), .step_req(step_req),
    .stop_req(stop_req), .step_n(step_n), .bp_en(bp_en), .bp_addr(bp_addr),
    .i_addr(i_addr), .wb_op(wb_op), .enable(enable), .start(start), .busy(busy),
    .state_o(state_o), .stop_cause(stop_cause), .cyc_cnt(cyc_cnt)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // CPU stand-in: pc, exec flag and opcodes in ID/EX/MEM/WB
  int         pc;
  bit         cpu_exec;
  logic [4:0] pipe [4];
  logic [4:0] prog [256];

  // Abstract controller model
  bit m_arm, m_run, m_halt, m_step;
  int m_left, m_cause, m_cnt;

  typedef struct {
    bit         rst;
    int         halt_at;
    bit         bpe;
    logic [7:0] bpa;
    int         req;        // 0 run, 1 step, 2 run+step together
    logic [7:0] n;
    int         stop_after; // EXEC cycle index that carries stop_req, 0 = none
    int         exp_cnt;
    int         exp_cause;
    int         exp_state;
    int         exp_pc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_arm = 0; m_run = 0; m_halt = 0; m_step = 0;
    m_left = 0; m_cause = 0; m_cnt = 0;
  endtask

  task automatic cpu_reset();
    pc = 0; cpu_exec = 0;
    for (int i = 0; i < 4; i++) pipe[i] = 5'd0;
  endtask

  task automatic clear_prog();
    for (int a = 0; a < 256; a++) prog[a] = 5'd0;
  endtask

  task automatic check_outputs();
    bit bph, e_en;
    int e_state;
    bph = bp_en && (i_addr == bp_addr);
    e_state = m_halt ? 3 : (m_run ? 2 : (m_arm ? 1 : 0));
    e_en = m_arm ? 1'b1 : (m_run ? !(stop_req || bph || (m_step && m_left == 1)) : 1'b0);
    chk("enable", 32'(enable), 32'(e_en));
    chk("start", 32'(start), 32'(m_arm));
    chk("busy", 32'(busy), 32'(m_arm || m_run));
    chk("state_o", 32'(state_o), 32'(e_state));
    if (!m_arm) chk("stop_cause", 32'(stop_cause), 32'(m_cause));
    chk("cyc_cnt", 32'(cyc_cnt), 32'(m_cnt));
    chk("exec_mirror", 32'(state_o == 2'b10), 32'(cpu_exec));
  endtask

  task automatic cpu_edge(input logic en, input logic st);
    bit halt_now;
    if (cpu_exec) begin
      halt_now = (pipe[3] == HALT);
      pipe[3] = pipe[2]; pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = prog[pc];
      pc = (pc + 1) % 256;
      if (!en || halt_now) cpu_exec = 0;
    end else if (en && st) begin
      cpu_exec = 1;
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit p, input bit bph,
                            input bit halt_w, input int n);
    bit last;
    if (m_halt) begin
      // only reset leaves
    end else if (m_arm) begin
      m_arm = 0; m_run = 1;
    end else if (m_run) begin
      last = m_step && (m_left == 1);
      m_cnt = (m_cnt + 1) % 65536;
      if (m_step) m_left = m_left - 1;
      if (halt_w)    begin m_run = 0; m_halt = 1; end
      else if (p)    begin m_run = 0; m_cause = 3; end
      else if (bph)  begin m_run = 0; m_cause = 2; end
      else if (last) begin m_run = 0; m_cause = 1; end
    end else if (r) begin
      m_arm = 1; m_step = 0; m_cause = 0;
    end else if (s) begin
      m_arm = 1; m_step = 1; m_cause = 0; m_left = (n == 0) ? 1 : n;
    end
  endtask

  // One clock: drive at negedge, check, cross the edge, update CPU and model
  task automatic cyc(input bit r, input bit s, input bit p);
    logic en_s, st_s;
    bit bph, halt_w;
    run_req = r; step_req = s; stop_req = p;
    i_addr = 8'(pc); wb_op = pipe[3];
    #1;
    check_outputs();
    en_s = enable; st_s = start;
    bph = bp_en && (i_addr == bp_addr);
    halt_w = (wb_op == HALT);
    @(posedge clock);
    cpu_edge(en_s, st_s);
    model_edge(r, s, p, bph, halt_w, int'(step_n));
    @(negedge clock);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    cpu_reset();
    run_req = 0; step_req = 0; stop_req = 0;
    i_addr = 8'(pc); wb_op = pipe[3];
    check_outputs();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    bit done;
    if (v.rst) do_reset();
    clear_prog();
    if (v.halt_at >= 0) prog[v.halt_at] = HALT;
    bp_en = v.bpe; bp_addr = v.bpa; step_n = v.n;
    cyc(v.req != 1, v.req != 0, 1'b0);
    k = 0; done = 0;
    while (!done && k < 300) begin
      cyc(1'b0, 1'b0, (v.stop_after > 0) && (k == v.stop_after));
      if (k > 0 && !m_arm && !m_run) done = 1;
      k++;
    end
    if (!done) chk($sformatf("vec%0d_timeout", idx), 32'd0, 32'd1);
    chk($sformatf("vec%0d_cnt", idx), 32'(cyc_cnt), 32'(v.exp_cnt));
    chk($sformatf("vec%0d_cause", idx), 32'(stop_cause), 32'(v.exp_cause));
    chk($sformatf("vec%0d_state", idx), 32'(state_o), 32'(v.exp_state));
    chk($sformatf("vec%0d_pc", idx), 32'(pc), 32'(v.exp_pc));
  endtask

  initial begin
    //           rst halt bpe bpa    req n     stop cnt cause st pc
    vecs[0] = '{1, -1, 0, 8'h00, 1, 8'd3, 0,  3, 1, 0, 3};
    vecs[1] = '{0, -1, 0, 8'h00, 1, 8'd0, 0,  4, 1, 0, 4};
    vecs[2] = '{1, -1, 1, 8'h05, 0, 8'd0, 0,  6, 2, 0, 6};
    vecs[3] = '{1, -1, 0, 8'h00, 0, 8'd0, 10, 10, 3, 0, 10};
    vecs[4] = '{0, -1, 0, 8'h00, 0, 8'd0, 3,  13, 3, 0, 13};
    vecs[5] = '{1, -1, 1, 8'h02, 1, 8'd3, 0,  3, 2, 0, 3};
    vecs[6] = '{1, -1, 0, 8'h01, 1, 8'd2, 0,  2, 1, 0, 2};
    vecs[7] = '{1, -1, 0, 8'h00, 1, 8'd1, 1,  1, 3, 0, 1};
    vecs[8] = '{1, -1, 0, 8'h00, 2, 8'd1, 4,  4, 3, 0, 4};
    vecs[9] = '{1,  4, 0, 8'h00, 0, 8'd0, 0,  9, 0, 3, 9};

    model_reset(); cpu_reset(); clear_prog();
    @(negedge clock);
    do_reset();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // HALTED ignores every request until reset
    cyc(1, 0, 0); cyc(0, 1, 0); cyc(1, 1, 1);
    chk("halted_state", 32'(state_o), 32'd3);
    chk("halted_cnt", 32'(cyc_cnt), 32'd9);
    chk("halted_pc", 32'(pc), 32'd9);
    do_reset();
    chk("post_halt_cnt", 32'(cyc_cnt), 32'd0);
    chk("post_halt_state", 32'(state_o), 32'd0);

    // Asynchronous reset between edges while in EXEC
    clear_prog(); bp_en = 0;
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    chk("pre_async_enable", 32'(enable), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_enable", 32'(enable), 32'd0);
    chk("async_state", 32'(state_o), 32'd0);
    chk("async_cnt", 32'(cyc_cnt), 32'd0);
    model_reset(); cpu_reset();
    @(negedge clock);
    reset = 1'b1;

    // run_req beats a simultaneous stop_req in IDLE; stop in ARM is ignored
    cyc(1, 0, 1);
    chk("run_over_stop", 32'(state_o), 32'd1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("arm_stop_cnt", 32'(cyc_cnt), 32'd1);
    chk("arm_stop_cause", 32'(stop_cause), 32'd3);

    // Random traffic against the model
    clear_prog(); prog[200] = HALT;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 49) == 0) bp_addr = 8'($urandom_range(0, 20));
        bp_en  = ($urandom_range(0, 3) == 0);
        step_n = 8'($urandom_range(0, 5));
        cyc($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
      end
    end

    // Counter wrap: 65536 EXEC cycles bring cyc_cnt back to 0
    do_reset();
    clear_prog(); bp_en = 0;
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    repeat (65535) cyc(0, 0, 0);
    chk("pre_wrap_cnt", 32'(cyc_cnt), 32'd65535);
    cyc(0, 0, 1);
    chk("wrap_cnt", 32'(cyc_cnt), 32'd0);
    chk("wrap_cause", 32'(stop_cause), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
